result_store_ctrl: RTL
======================

Name: result_store_ctrl

Overview:
Consumer end of the MAC array result interface. It captures the four 18-bit accumulator results (MU1..MU4) on every `web` pulse, queues them, and drains them one word per cycle into the single-port output SRAM. It signals completion once `ALU_done` has been seen and every queued result is written. It also arbitrates host readback of the stored output matrix through the same SRAM port.

Parameters:
- NUM_GROUPS, 4: `web` pulses (4-result groups) per matrix; output words per matrix = 4*NUM_GROUPS.
- ADDR_W, 4: SRAM address width; must satisfy 2^ADDR_W >= 4*NUM_GROUPS.
- OUT_W, 16: SRAM data width, which is also the stored result width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- MU1  in  18  lane-0 result.
- MU2  in  18  lane-1 result.
- MU3  in  18  lane-2 result.
- MU4  in  18  lane-3 result.
- web  in  1  one-cycle strobe: MU1..MU4 valid this cycle.
- ALU_done  in  1  one-cycle strobe: last group of the matrix issued.
- ram_cen  out  1  SRAM enable, active-high.
- ram_we  out  1  SRAM write enable (1 = write, 0 = read).
- ram_addr  out  ADDR_W  SRAM address.
- ram_wdata  out  OUT_W  SRAM write data.
- ram_rdata  in  OUT_W  SRAM read data, valid the cycle after a read strobe.
- rd_req  in  1  host read request (level).
- rd_addr  in  ADDR_W  host read address.
- rd_gnt  out  1  host request accepted this cycle.
- rd_valid  out  1  rd_data valid, asserted the cycle after rd_gnt.
- rd_data  out  OUT_W  host read data.
- store_done  out  1  one-cycle pulse: matrix fully written.
- ovf_err  out  1  sticky error: a group was dropped.

Behaviour:
- Reset: all outputs are 0; queue is empty; group index = 0; lane = 0; state = IDLE. A reset mid-drain discards queued data and issues no further SRAM strobes.
- Queue: 2 slots, each holding 4x18 bits, with write pointer, read pointer and count (0..2).
  - `web` = 1 with count < 2, or with count = 2 and the last lane of the head slot draining this cycle: capture MU1..MU4 into the tail slot at the rising edge.
  - `web` = 1 with count = 2 and no drain completing: group dropped, `ovf_err` <= 1 until reset.
- Drain: while count > 0, one write per cycle with `ram_cen` = 1, `ram_we` = 1, `ram_addr` = group_idx*4 + lane, `ram_wdata` = lane result reduced to OUT_W (see Optional Feature).
  - Lane advances 0 to 3; after lane 3 the slot pops and group_idx increments.
- Latency: `web` at cycle t puts lane 0 on the SRAM port in cycle t+1 and lane 3 in t+4, when the queue was empty.
- Extra groups: a `web` when NUM_GROUPS groups have already been accepted this matrix is ignored and sets `ovf_err`.
- FSM:
  - IDLE: any `web` goes to COLLECT (capture occurs). `ALU_done` goes to FLUSH.
  - COLLECT: `ALU_done` goes to FLUSH. A `web` in the same cycle is captured.
  - FLUSH: no further captures (`web` ignored, `ovf_err` set). When count = 0 and no write in flight, go to DONE.
  - DONE: `store_done` = 1 for exactly one cycle; group_idx and lane clear to 0; go to IDLE.
  - `ALU_done` with zero groups accepted still passes through FLUSH and DONE.
- Host read:
  - `rd_gnt` = `rd_req` while state = IDLE and count = 0; otherwise held 0 and the request stalls.
  - A grant drives `ram_cen` = 1, `ram_we` = 0, `ram_addr` = `rd_addr`.
  - Next cycle: `rd_valid` = 1, `rd_data` = `ram_rdata`.
  - Writes always win; a `web` arriving in IDLE blocks the grant in that cycle.
  - Back-to-back reads run at one per cycle.
- Arithmetic: results are unsigned; no sign handling.

Optional Feature:
RESULT_SAT_EN.
- Defined: lane value > 2^OUT_W-1 writes all-ones (OUT_W bits).
- Undefined: writes the lower OUT_W bits (truncation).

Test Plan:
- Single group: MU = 1,2,3,4 with `web` at t, then `ALU_done` at t+8 -> writes (addr 0..3, data 1..4) in t+1..t+4; `store_done` pulses once after FLUSH.
- Full matrix: 4 groups with `web` every 8 cycles, values g*4+k, last `web` coinciding with `ALU_done` -> SRAM addr g*4+k holds g*4+k for addresses 0..15; `store_done` pulses once; `ovf_err` = 0.
- Overflow: three `web` pulses on consecutive cycles -> first two groups written (8 writes); third dropped; `ovf_err` = 1 and held until `rst`.
- Saturation: MU1 = 18'h2_0001 -> 16'h0001 without RESULT_SAT_EN; 16'hFFFF with it.
- Read arbitration: `rd_req` at addr 5 while draining -> `rd_gnt` = 0 until the queue is empty and state = IDLE; then `rd_gnt` for one cycle; `rd_valid` next cycle with the stored word.
- Reset mid-drain: assert `rst` after lane 1 of a group -> next cycle `ram_cen` = 0 and all outputs are 0; a subsequent matrix writes starting at addr 0.

Source files
------------

// File: rtl/result_store_ctrl.sv
// Result store controller: queues 4-lane MAC results and drains them into the output SRAM.
// Host readback shares the SRAM port. Define RESULT_SAT_EN to saturate lane values, otherwise they truncate.
module result_store_ctrl #(
  parameter int NUM_GROUPS = 4,
  parameter int ADDR_W     = 4,
  parameter int OUT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [17:0]       MU1,
  input  logic [17:0]       MU2,
  input  logic [17:0]       MU3,
  input  logic [17:0]       MU4,
  input  logic              web,
  input  logic              ALU_done,
  output logic              ram_cen,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [OUT_W-1:0]  ram_wdata,
  input  logic [OUT_W-1:0]  ram_rdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [OUT_W-1:0]  rd_data,
  output logic              store_done,
  output logic              ovf_err
);

  localparam int GW = $clog2(NUM_GROUPS + 1);

`ifdef RESULT_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [17:0]     slot_q [2][4];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic [1:0]      lane_q, lane_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [GW-1:0]   acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            rd_valid_q;

  logic            drain_s, pop_s, open_s, room_s, space_s, cap_s, drop_s, gnt_s;
  logic [17:0]     lane_val_s;
  logic [ADDR_W-1:0] wr_addr_s;

  // Values above the OUT_W range either clip to all-ones or lose their upper bits.
  function automatic logic [OUT_W-1:0] reduce_lane(input logic [17:0] v);
    logic hi;
    hi = |(v >> OUT_W);
    if (SAT_EN && hi) begin
      return {OUT_W{1'b1}};
    end else begin
      return OUT_W'(v);
    end
  endfunction

  // Queue control, capture/drop decisions and FSM next state.
  always_comb begin
    drain_s    = (count_q != 2'd0);
    pop_s      = drain_s && (lane_q == 2'd3);
    open_s     = (state_q == IDLE) || (state_q == COLLECT);
    room_s     = (acc_q < GW'(NUM_GROUPS));
    space_s    = (count_q < 2'd2) || pop_s;
    cap_s      = web && open_s && room_s && space_s;
    drop_s     = web && !cap_s;
    gnt_s      = rd_req && (state_q == IDLE) && (count_q == 2'd0) && !web && !rst;
    lane_val_s = slot_q[rd_ptr_q][lane_q];
    wr_addr_s  = (ADDR_W'(grp_q) << 2'd2) | ADDR_W'(lane_q);

    wr_ptr_d = cap_s ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
    ovf_d    = ovf_q | drop_s;

    case ({cap_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (state_q == DONE) begin
      lane_d = 2'd0;
      grp_d  = '0;
      acc_d  = '0;
    end else begin
      lane_d = drain_s ? lane_q + 2'd1 : lane_q;
      grp_d  = pop_s ? grp_q + GW'(1) : grp_q;
      acc_d  = cap_s ? acc_q + GW'(1) : acc_q;
    end

    case (state_q)
      IDLE: begin
        if (ALU_done) begin
          state_d = FLUSH;
        end else if (web) begin
          state_d = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: state_d = ALU_done ? FLUSH : COLLECT;
      FLUSH:   state_d = (count_q == 2'd0) ? DONE : FLUSH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, queue storage and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      lane_q     <= 2'd0;
      grp_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        for (int l = 0; l < 4; l++) begin
          slot_q[s][l] <= 18'd0;
        end
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lane_q     <= lane_d;
      grp_q      <= grp_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= gnt_s;
      if (cap_s) begin
        slot_q[wr_ptr_q][0] <= MU1;
        slot_q[wr_ptr_q][1] <= MU2;
        slot_q[wr_ptr_q][2] <= MU3;
        slot_q[wr_ptr_q][3] <= MU4;
      end
    end
  end

  // SRAM port: queued writes take priority, a granted host read uses the port otherwise.
  always_comb begin
    ram_cen = !rst && (drain_s || gnt_s);
    ram_we  = !rst && drain_s;
    if (rst) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end else if (drain_s) begin
      ram_addr  = wr_addr_s;
      ram_wdata = reduce_lane(lane_val_s);
    end else if (gnt_s) begin
      ram_addr  = rd_addr;
      ram_wdata = '0;
    end else begin
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  assign rd_gnt     = gnt_s;
  assign rd_valid   = rd_valid_q && !rst;
  assign rd_data    = (rd_valid_q && !rst) ? ram_rdata : '0;
  assign store_done = (state_q == DONE) && !rst;
  assign ovf_err    = ovf_q;

endmodule
